// File: rtl/kyber_pkg.sv
// Shared constants and sequencer state encoding for the Kyber polynomial
// arithmetic blocks.
package kyber_pkg;

   localparam int Q              = 3329;
   localparam int DATA_WIDTH_DEF = 14;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } state_t;

endpackage

// File: rtl/modular_substraction.sv
// Combinational modular subtraction z = (x - y) mod Q.
// A borrow out of the widened difference means the result went negative.
module modular_substraction
   import kyber_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic [DATA_WIDTH-1:0] x,
   input  logic [DATA_WIDTH-1:0] y,
   output logic [DATA_WIDTH-1:0] z
);

   logic [DATA_WIDTH:0] diff;

   assign diff = {1'b0, x} - {1'b0, y};

   // Out-of-range inputs are not folded further; the truncated value is returned.
   assign z = diff[DATA_WIDTH] ? (diff[DATA_WIDTH-1:0] + DATA_WIDTH'(Q))
                               : diff[DATA_WIDTH-1:0];

endmodule

// File: rtl/poly_sub_seq.sv
// Streams c[i] = (a[i] - b[i]) mod Q over one polynomial, one coefficient per
// cycle, from shared-address A/B memories into a registered C write port.
//
// state | meaning
// IDLE  | waiting for start; len sampled here
// ISSUE | one A/B read per cycle, rd_addr counting up from 0
// DRAIN | reads finished, waiting for the last write to leave the pipeline
// DONE  | one-cycle done pulse
module poly_sub_seq
   import kyber_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = 8,
   parameter int N_COEFF    = 256,
   parameter int RAM_LAT    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   len,
   output logic                  busy,
   output logic                  done,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_a,
   input  logic [DATA_WIDTH-1:0] rd_b,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data
);

   state_t                state_q;
   state_t                state_nxt;
   logic [ADDR_WIDTH:0]   len_clamped;
   logic [ADDR_WIDTH:0]   remain_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  issue_last;
   logic [RAM_LAT-1:0]    pipe_vld;
   logic [ADDR_WIDTH-1:0] pipe_addr [RAM_LAT];
   logic [DATA_WIDTH-1:0] diff;

   assign len_clamped = (len > (ADDR_WIDTH+1)'(N_COEFF)) ? (ADDR_WIDTH+1)'(N_COEFF) : len;

   // Remaining-reads down-counter; the final read is issued at terminal count 1.
   assign issue_last = (remain_q == (ADDR_WIDTH+1)'(1));

   assign rd_en   = (state_q == ISSUE);
   assign rd_addr = rd_en ? addr_q : '0;
   assign busy    = (state_q == ISSUE) || (state_q == DRAIN);
   assign done    = (state_q == DONE);

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_nxt = (len_clamped == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            if (issue_last) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            // The pipeline never has bubbles, so an empty pipe behind a write marks the last one.
            if (wr_en && (pipe_vld == '0)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   modular_substraction #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_sub (
      .x(rd_a),
      .y(rd_b),
      .z(diff)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         remain_q <= '0;
         addr_q   <= '0;
         pipe_vld <= '0;
         for (int k = 0; k < RAM_LAT; k++) begin
            pipe_addr[k] <= '0;
         end
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
      end else begin
         state_q <= state_nxt;

         if ((state_q == IDLE) && start) begin
            remain_q <= len_clamped;
            addr_q   <= '0;
         end else if (rd_en) begin
            remain_q <= remain_q - (ADDR_WIDTH+1)'(1);
            addr_q   <= addr_q + ADDR_WIDTH'(1);
         end

         // Stage RAM_LAT-1 lines up with the memory data for the same address.
         pipe_vld[0]  <= rd_en;
         pipe_addr[0] <= rd_addr;
         for (int k = 1; k < RAM_LAT; k++) begin
            pipe_vld[k]  <= pipe_vld[k-1];
            pipe_addr[k] <= pipe_addr[k-1];
         end

         wr_en <= pipe_vld[RAM_LAT-1];
         if (pipe_vld[RAM_LAT-1]) begin
            wr_addr <= pipe_addr[RAM_LAT-1];
            wr_data <= diff;
         end
      end
   end

endmodule

// File: tb/tb_poly_sub_seq.sv
// Self-checking bench for poly_sub_seq: two instances (RAM_LAT=1 and RAM_LAT=3)
// with behavioural memories, event logs and an arithmetic reference model.
module tb_poly_sub_seq;

   localparam int DW = 14;
   localparam int AW = 8;
   localparam int NC = 256;

   typedef struct {
      int cyc;
      int addr;
      int data;
   } wr_ev_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start1 = 1'b0, start3 = 1'b0;
   logic [AW:0]   len1 = '0, len3 = '0;
   logic          busy1, done1, rd_en1, wr_en1;
   logic          busy3, done3, rd_en3, wr_en3;
   logic [AW-1:0] rd_addr1, wr_addr1, rd_addr3, wr_addr3;
   logic [DW-1:0] rd_a1 = '0, rd_b1 = '0, wr_data1, wr_data3;
   logic [DW-1:0] rd_a3, rd_b3;
   logic [DW-1:0] pa [3];
   logic [DW-1:0] pb [3];
   logic [DW-1:0] mem_a [NC];
   logic [DW-1:0] mem_b [NC];

   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;

   wr_ev_t wq1[$], wq3[$];
   int     dq1[$], dq3[$];
   int     bcnt1, blast1, rdcnt1, clash1, bcnt3, rdcnt3;
   int     hold_bad;
   logic [DW-1:0] last_wd1 = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   poly_sub_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_COEFF(NC), .RAM_LAT(1)) dut (
      .clk(clk), .rst(rst), .start(start1), .len(len1), .busy(busy1), .done(done1),
      .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_a(rd_a1), .rd_b(rd_b1),
      .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1)
   );

   poly_sub_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_COEFF(NC), .RAM_LAT(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .len(len3), .busy(busy3), .done(done3),
      .rd_en(rd_en3), .rd_addr(rd_addr3), .rd_a(rd_a3), .rd_b(rd_b3),
      .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3)
   );

   // Behavioural memories: latency 1 and latency 3
   always @(posedge clk) begin
      rd_a1 <= rd_en1 ? mem_a[rd_addr1] : '0;
      rd_b1 <= rd_en1 ? mem_b[rd_addr1] : '0;
      pa[0] <= rd_en3 ? mem_a[rd_addr3] : '0;
      pb[0] <= rd_en3 ? mem_b[rd_addr3] : '0;
      pa[1] <= pa[0];
      pb[1] <= pb[0];
      pa[2] <= pa[1];
      pb[2] <= pb[1];
   end
   assign rd_a3 = pa[2];
   assign rd_b3 = pb[2];

   // Event logger, sampled mid-cycle
   always @(negedge clk) begin
      if (wr_en1) wq1.push_back('{cyc, int'(wr_addr1), int'(wr_data1)});
      if (wr_en3) wq3.push_back('{cyc, int'(wr_addr3), int'(wr_data3)});
      if (done1) dq1.push_back(cyc);
      if (done3) dq3.push_back(cyc);
      if (busy1) begin bcnt1++; blast1 = cyc; end
      if (busy3) bcnt3++;
      if (busy1 && done1) clash1++;
      if (rd_en1) rdcnt1++;
      if (rd_en3) rdcnt3++;
      if (!rd_en1 && rd_addr1 != '0) hold_bad++;
      if (!wr_en1 && !rst && wr_data1 != last_wd1) hold_bad++;
      if (wr_en1) last_wd1 = wr_data1;
      if (rst) last_wd1 = '0;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, actual running required finished");
      $fatal(1, "watchdog");
   end

   function automatic int ref_sub(int a, int b);
      return ((a - b) % 3329 + 3329) % 3329;
   endfunction

   // Index of the first logged write disagreeing with the model, or -1
   function automatic int first_bad(input wr_ev_t q[$], input int s, input int n, input int lat);
      for (int i = 0; i < q.size(); i++) begin
         if (i >= n || q[i].cyc != s + 2 + i + lat || q[i].addr != i ||
             q[i].data != ref_sub(int'(mem_a[i]), int'(mem_b[i])))
            return i;
      end
      return -1;
   endfunction

   task automatic clear_log();
      wq1.delete(); wq3.delete(); dq1.delete(); dq3.delete();
      bcnt1 = 0; blast1 = -1; rdcnt1 = 0; clash1 = 0; bcnt3 = 0; rdcnt3 = 0;
   endtask

   task automatic wait_cycles(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_run(int sel, int n, output int s);
      @(negedge clk);
      if (sel == 0) begin start1 = 1'b1; len1 = (AW+1)'(n); end
      else begin start3 = 1'b1; len3 = (AW+1)'(n); end
      s = cyc;
      @(negedge clk);
      start1 = 1'b0; len1 = '0; start3 = 1'b0; len3 = '0;
   endtask

   task automatic fill_random();
      for (int i = 0; i < NC; i++) begin
         mem_a[i] = DW'($urandom_range(0, 3328));
         mem_b[i] = DW'($urandom_range(0, 3328));
      end
      mem_a[0] = 0;    mem_b[0] = 3328;
      mem_a[1] = 3328; mem_b[1] = 0;
      mem_a[2] = 1234; mem_b[2] = 1234;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      wait_cycles(3);
      n_chk++;
      if ({busy1, done1, rd_en1, wr_en1} !== 4'b0 || rd_addr1 !== '0 || wr_addr1 !== '0 || wr_data1 !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%0b done=%0b rd_en=%0b wr_en=%0b rd_addr=%0d wr_addr=%0d wr_data=%0d, want all 0",
                  busy1, done1, rd_en1, wr_en1, rd_addr1, wr_addr1, wr_data1);
      end
      n_chk++;
      if ({busy3, done3, rd_en3, wr_en3} !== 4'b0 || wr_data3 !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs_lat3: got busy=%0b done=%0b rd_en=%0b wr_en=%0b wr_data=%0d, want all 0",
                  busy3, done3, rd_en3, wr_en3, wr_data3);
      end
      rst = 1'b0;
      wait_cycles(2);
   endtask

   task automatic test_directed();
      int s;
      int exp_d[3] = '{2, 3327, 1};
      mem_a[0] = 5; mem_a[1] = 3; mem_a[2] = 0;
      mem_b[0] = 3; mem_b[1] = 5; mem_b[2] = 3328;
      clear_log();
      start_run(0, 3, s);
      wait_cycles(10);
      n_chk++;
      if (wq1.size() !== 3) begin
         n_fail++; $display("FAIL directed_count: got %0d writes, want 3", wq1.size());
      end
      for (int i = 0; i < wq1.size() && i < 3; i++) begin
         n_chk++;
         if (wq1[i].cyc !== s + 3 + i || wq1[i].addr !== i || wq1[i].data !== exp_d[i]) begin
            n_fail++;
            $display("FAIL directed_write%0d: got cyc=S+%0d addr=%0d data=%0d, want cyc=S+%0d addr=%0d data=%0d",
                     i, wq1[i].cyc - s, wq1[i].addr, wq1[i].data, 3 + i, i, exp_d[i]);
         end
      end
      n_chk++;
      if (dq1.size() != 1 || dq1[0] != s + 6) begin
         n_fail++; $display("FAIL directed_done: got %0d pulses first=S+%0d, want 1 at S+6",
                            dq1.size(), dq1.size() > 0 ? dq1[0] - s : -1);
      end
      n_chk++;
      if (bcnt1 !== 5 || blast1 !== s + 5 || clash1 !== 0) begin
         n_fail++; $display("FAIL directed_busy: got %0d cycles last=S+%0d clash=%0d, want 5 last=S+5 clash=0",
                            bcnt1, blast1 - s, clash1);
      end
   endtask

   task automatic test_random();
      int s, bad;
      fill_random();
      clear_log();
      start_run(0, 256, s);
      wait_cycles(270);
      bad = first_bad(wq1, s, 256, 1);
      n_chk++;
      if (wq1.size() !== 256) begin
         n_fail++; $display("FAIL random_count: got %0d writes, want 256", wq1.size());
      end
      n_chk++;
      if (bad !== -1) begin
         n_fail++;
         $display("FAIL random_write%0d: got cyc=S+%0d addr=%0d data=%0d, want cyc=S+%0d addr=%0d data=%0d",
                  bad, wq1[bad].cyc - s, wq1[bad].addr, wq1[bad].data, bad + 3, bad,
                  ref_sub(int'(mem_a[bad]), int'(mem_b[bad])));
      end
      n_chk++;
      if (dq1.size() != 1 || dq1[0] != s + 259) begin
         n_fail++; $display("FAIL random_done: got %0d pulses first=S+%0d, want 1 at S+259",
                            dq1.size(), dq1.size() > 0 ? dq1[0] - s : -1);
      end
      n_chk++;
      if (bcnt1 !== 258 || blast1 !== s + 258 || rdcnt1 !== 256 || clash1 !== 0) begin
         n_fail++; $display("FAIL random_busy: got busy=%0d last=S+%0d reads=%0d clash=%0d, want 258 S+258 256 0",
                            bcnt1, blast1 - s, rdcnt1, clash1);
      end
   endtask

   task automatic test_restart_ignored();
      int s, bad;
      fill_random();
      clear_log();
      start_run(0, 256, s);
      wait_cycles(9);
      start1 = 1'b1; len1 = 9'd7;
      @(negedge clk);
      start1 = 1'b0; len1 = '0;
      wait_cycles(260);
      bad = first_bad(wq1, s, 256, 1);
      n_chk++;
      if (wq1.size() !== 256 || bad !== -1) begin
         n_fail++; $display("FAIL restart_writes: got %0d writes first_bad=%0d, want 256 and -1", wq1.size(), bad);
      end
      n_chk++;
      if (dq1.size() != 1 || dq1[0] != s + 259) begin
         n_fail++; $display("FAIL restart_done: got %0d pulses first=S+%0d, want 1 at S+259",
                            dq1.size(), dq1.size() > 0 ? dq1[0] - s : -1);
      end
   endtask

   task automatic test_clamp();
      int s;
      clear_log();
      start_run(0, 400, s);
      wait_cycles(270);
      n_chk++;
      if (wq1.size() !== 256 || first_bad(wq1, s, 256, 1) !== -1 || dq1.size() != 1 || dq1[0] != s + 259) begin
         n_fail++; $display("FAIL clamp: got %0d writes %0d done pulses, want 256 writes and done at S+259",
                            wq1.size(), dq1.size());
      end
   endtask

   task automatic test_len_zero();
      int s;
      clear_log();
      start_run(0, 0, s);
      wait_cycles(5);
      n_chk++;
      if (dq1.size() != 1 || dq1[0] != s + 1) begin
         n_fail++; $display("FAIL len0_done: got %0d pulses first=S+%0d, want 1 at S+1",
                            dq1.size(), dq1.size() > 0 ? dq1[0] - s : -1);
      end
      n_chk++;
      if (rdcnt1 !== 0 || wq1.size() !== 0 || bcnt1 !== 0) begin
         n_fail++; $display("FAIL len0_activity: got reads=%0d writes=%0d busy=%0d, want 0 0 0",
                            rdcnt1, wq1.size(), bcnt1);
      end
   endtask

   task automatic test_reset_mid_run();
      int s, bad;
      fill_random();
      clear_log();
      start_run(0, 256, s);
      wait_cycles(49);
      rst = 1'b1;
      @(negedge clk);
      n_chk++;
      if ({busy1, done1, rd_en1, wr_en1} !== 4'b0 || rd_addr1 !== '0 || wr_addr1 !== '0 || wr_data1 !== '0) begin
         n_fail++;
         $display("FAIL midrst_outputs: got busy=%0b done=%0b rd_en=%0b wr_en=%0b rd_addr=%0d wr_addr=%0d wr_data=%0d, want all 0",
                  busy1, done1, rd_en1, wr_en1, rd_addr1, wr_addr1, wr_data1);
      end
      rst = 1'b0;
      wait_cycles(280);
      bad = first_bad(wq1, s, 256, 1);
      n_chk++;
      if (wq1.size() !== 48 || bad !== -1 || dq1.size() !== 0) begin
         n_fail++; $display("FAIL midrst_abort: got %0d writes first_bad=%0d done=%0d, want 48 -1 0",
                            wq1.size(), bad, dq1.size());
      end
      clear_log();
      start_run(0, 4, s);
      wait_cycles(10);
      n_chk++;
      if (wq1.size() !== 4 || first_bad(wq1, s, 4, 1) !== -1 || dq1.size() != 1 || dq1[0] != s + 7) begin
         n_fail++; $display("FAIL midrst_rerun: got %0d writes %0d done pulses, want 4 writes and done at S+7",
                            wq1.size(), dq1.size());
      end
   endtask

   task automatic test_lat3();
      int s, bad;
      fill_random();
      clear_log();
      start_run(1, 4, s);
      wait_cycles(12);
      bad = first_bad(wq3, s, 4, 3);
      n_chk++;
      if (wq3.size() !== 4 || bad !== -1) begin
         n_fail++; $display("FAIL lat3_writes: got %0d writes first_bad=%0d, want 4 and -1", wq3.size(), bad);
      end
      n_chk++;
      if (wq3.size() > 0 && wq3[0].cyc !== s + 5) begin
         n_fail++; $display("FAIL lat3_first: got first write at S+%0d, want S+5", wq3[0].cyc - s);
      end
      n_chk++;
      if (dq3.size() != 1 || dq3[0] != s + 9 || bcnt3 !== 8 || rdcnt3 !== 4) begin
         n_fail++; $display("FAIL lat3_done: got %0d pulses first=S+%0d busy=%0d reads=%0d, want 1 S+9 8 4",
                            dq3.size(), dq3.size() > 0 ? dq3[0] - s : -1, bcnt3, rdcnt3);
      end
   endtask

   task automatic test_hold();
      n_chk++;
      if (hold_bad !== 0) begin
         n_fail++; $display("FAIL hold: got %0d idle-cycle changes on rd_addr/wr_data, want 0", hold_bad);
      end
   endtask

   initial begin
      hold_bad = 0;
      clear_log();
      test_reset();
      test_directed();
      test_random();
      test_restart_ignored();
      test_clamp();
      test_len_zero();
      test_reset_mid_run();
      test_lat3();
      test_hold();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
